// File: rtl/axi_sram_slave.sv
// axi_sram_slave
// AXI3 slave responder backed by a word-addressed SRAM array of
// 2^DEPTH_LOG2 32-bit words. Supports one outstanding read and one
// outstanding write, each with INCR/FIXED bursts (WRAP behaves as INCR).
// The read and write paths are independent FSMs that share a dual-port
// array: one read port and one byte-strobed write port.
//
// Ports
//   aclk, areset            clock, asynchronous active-high reset
//   ar*                     read address channel (lock/cache/prot ignored)
//   r*                      read data channel
//   aw*                     write address channel (lock/cache/prot ignored)
//   w*                      write data channel (wid ignored)
//   b*                      write response channel
//   dbg_rstate, dbg_wstate  current read / write FSM state
//
// Handshake rule on every channel: a transfer happens on the rising edge
// where valid && ready are both high. Once this block raises a valid it
// holds it, with its payload unchanged, until that transfer happens.
module axi_sram_slave #(
  parameter int DEPTH_LOG2 = 14
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  output logic        dbg_rstate,
  output logic [1:0]  dbg_wstate
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic { R_IDLE = 1'b0, R_DATA = 1'b1 } r_state_t;
  typedef enum logic [1:0] { W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2 } w_state_t;

  // Contents are deliberately not reset.
  logic [31:0] r_mem [DEPTH];

  // Sideband fields this responder does not act on.
  logic w_unused;
  assign w_unused = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

  // Sizes above 4 bytes collapse to 4: data is always a full word.
  function automatic logic [1:0] clamp_size(input logic [2:0] sz);
    return (sz > 3'd2) ? 2'd2 : sz[1:0];
  endfunction

  // FIXED holds the address; INCR and WRAP both step by the beat size.
  function automatic logic [31:0] next_addr(input logic [31:0] a,
                                            input logic [1:0]  sz,
                                            input logic [1:0]  burst);
    return (burst == 2'b00) ? a : a + (32'd1 << sz);
  endfunction

  // ---------------- read path ----------------
  r_state_t    r_rstate;
  logic [3:0]  r_rid;
  logic [7:0]  r_rlen;
  logic [1:0]  r_rsize;
  logic [1:0]  r_rburst;
  logic [31:0] r_raddr;
  logic [7:0]  r_rcnt;
  logic [31:0] r_rdata;
  logic        r_rvalid;
  logic        r_rlast;
  logic [31:0] w_raddr_next;

  assign w_raddr_next = next_addr(r_raddr, r_rsize, r_rburst);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_rstate <= R_IDLE;
      r_rid    <= '0;
      r_rlen   <= '0;
      r_rsize  <= '0;
      r_rburst <= '0;
      r_raddr  <= '0;
      r_rcnt   <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (arvalid) begin
            r_rid    <= arid;
            r_rlen   <= arlen;
            r_rsize  <= clamp_size(arsize);
            r_rburst <= arburst;
            r_raddr  <= araddr;
            r_rcnt   <= '0;
            r_rdata  <= r_mem[araddr[DEPTH_LOG2+1:2]];
            r_rvalid <= 1'b1;
            r_rlast  <= (arlen == 8'd0);
            r_rstate <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (r_rlast) begin
              r_rvalid <= 1'b0;
              r_rlast  <= 1'b0;
              r_rstate <= R_IDLE;
            end else begin
              // Next beat is fetched in the same cycle the current one is taken.
              r_rcnt  <= r_rcnt + 8'd1;
              r_raddr <= w_raddr_next;
              r_rdata <= r_mem[w_raddr_next[DEPTH_LOG2+1:2]];
              r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
            end
          end
        end
      endcase
    end
  end

  assign arready    = (r_rstate == R_IDLE);
  assign rid        = r_rid;
  assign rdata      = r_rdata;
  assign rresp      = 2'b00;
  assign rlast      = r_rlast;
  assign rvalid     = r_rvalid;
  assign dbg_rstate = r_rstate;

  // ---------------- write path ----------------
  w_state_t    r_wstate;
  logic [3:0]  r_bid;
  logic [7:0]  r_wlen;
  logic [1:0]  r_wsize;
  logic [1:0]  r_wburst;
  logic [31:0] r_waddr;
  logic [7:0]  r_wcnt;
  logic        r_werr;
  logic        r_bvalid;
  logic [1:0]  r_bresp;
  logic        w_wfire;
  logic        w_wfinal;

  assign w_wfire  = wvalid && (r_wstate == W_DATA);
  assign w_wfinal = (r_wcnt == r_wlen);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wstate <= W_IDLE;
      r_bid    <= '0;
      r_wlen   <= '0;
      r_wsize  <= '0;
      r_wburst <= '0;
      r_waddr  <= '0;
      r_wcnt   <= '0;
      r_werr   <= 1'b0;
      r_bvalid <= 1'b0;
      r_bresp  <= 2'b00;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (awvalid) begin
            r_bid    <= awid;
            r_wlen   <= awlen;
            r_wsize  <= clamp_size(awsize);
            r_wburst <= awburst;
            r_waddr  <= awaddr;
            r_wcnt   <= '0;
            r_werr   <= 1'b0;
            r_wstate <= W_DATA;
          end
        end
        W_DATA: begin
          if (wvalid) begin
            // The burst always ends on the beat count; wlast only grades it.
            if (w_wfinal) begin
              r_bvalid <= 1'b1;
              r_bresp  <= (r_werr || !wlast) ? 2'b10 : 2'b00;
              r_wstate <= W_RESP;
            end else begin
              r_wcnt  <= r_wcnt + 8'd1;
              r_waddr <= next_addr(r_waddr, r_wsize, r_wburst);
              r_werr  <= r_werr || wlast;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            r_bvalid <= 1'b0;
            r_werr   <= 1'b0;
            r_wstate <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Byte-strobed write port; a same-cycle read of this word sees old data.
  always_ff @(posedge aclk) begin
    if (w_wfire) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) r_mem[r_waddr[DEPTH_LOG2+1:2]][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign awready    = (r_wstate == W_IDLE);
  assign wready     = (r_wstate == W_DATA);
  assign bid        = r_bid;
  assign bresp      = r_bresp;
  assign bvalid     = r_bvalid;
  assign dbg_wstate = r_wstate;

endmodule

// File: tb/tb_axi_sram_slave.sv
module tb_axi_sram_slave;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic areset = 1'b0;
  always #5 aclk = ~aclk;

  logic [3:0]  arid = '0, awid = '0, wid = '0;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
  logic [7:0]  arlen = '0, awlen = '0;
  logic [2:0]  arsize = 3'd2, awsize = 3'd2, arprot = '0, awprot = '0;
  logic [1:0]  arburst = 2'b01, awburst = 2'b01, arlock = '0, awlock = '0;
  logic [3:0]  arcache = '0, awcache = '0, wstrb = '0;
  logic        arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
  logic        rready = 1'b0, bready = 1'b0;
  logic        arready, awready, wready, rvalid, rlast, bvalid, dbg_rstate;
  logic [3:0]  rid, bid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp, dbg_wstate;

  axi_sram_slave #(.DEPTH_LOG2(14)) dut (
    .aclk(aclk), .areset(areset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .dbg_rstate(dbg_rstate), .dbg_wstate(dbg_wstate)
  );

  // ---------------- reference model / scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] m  [0:16383];
  bit          mk [0:16383];
  logic [31:0] wd_buf [0:15];
  logic [3:0]  ws_buf [0:15];
  logic [31:0] last_rdata;

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 32'd16384);
  endfunction

  function automatic logic [31:0] adv(input logic [31:0] a, input logic [2:0] sz,
                                      input logic [1:0] b);
    int step;
    if (b == 2'b00) return a;
    step = (sz > 3'd2) ? 4 : (1 << sz);
    return a + 32'(step);
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int k;
    k = widx(a);
    for (int i = 0; i < 4; i++) if (s[i]) m[k][8*i +: 8] = d[8*i +: 8];
    mk[k] = mk[k] || (s == 4'hF);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input int bad_beat, input bit rnd);
    logic [31:0] a;
    logic [1:0]  exp_resp;
    a = addr;
    exp_resp = (bad_beat >= 0 && bad_beat != int'(len)) ? 2'b10 : 2'b00;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    chk("awready_idle", awready, 1);
    tick;
    awvalid = 1'b0;
    for (int beat = 0; beat <= int'(len); beat++) begin
      wvalid = 1'b1; wdata = wd_buf[beat]; wstrb = ws_buf[beat];
      wlast = (bad_beat >= 0) ? (beat == bad_beat) : (beat == int'(len));
      chk("wready", wready, 1);
      tick;
      model_write(a, wd_buf[beat], ws_buf[beat]);
      a = adv(a, size, burst);
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("bvalid_after_w", bvalid, 1);
    chk("wready_off", wready, 0);
    if (rnd) begin
      for (int s = 0; s < int'($urandom_range(0, 2)); s++) begin
        tick;
        chk("bvalid_hold", bvalid, 1);
      end
    end
    chk("bid", bid, 32'(id));
    chk("bresp", bresp, 32'(exp_resp));
    bready = 1'b1;
    tick;
    bready = 1'b0;
    chk("bvalid_drop", bvalid, 0);
    chk("awready_back", awready, 1);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input int stall_beat, input int stall_n, input bit rnd);
    logic [31:0] a;
    int k, stalls;
    a = addr;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    chk("arready_idle", arready, 1);
    tick;
    arvalid = 1'b0;
    chk("rvalid_after_ar", rvalid, 1);
    for (int beat = 0; beat <= int'(len); beat++) begin
      k = widx(a);
      stalls = (beat == stall_beat) ? stall_n : (rnd ? int'($urandom_range(0, 2)) : 0);
      rready = 1'b0;
      for (int s = 0; s < stalls; s++) begin
        chk("rvalid_hold", rvalid, 1);
        if (mk[k]) chk("rdata_hold", rdata, m[k]);
        tick;
      end
      rready = 1'b1;
      chk("rvalid", rvalid, 1);
      if (mk[k]) chk("rdata", rdata, m[k]);
      chk("rid", rid, 32'(id));
      chk("rresp", rresp, 0);
      chk("rlast", rlast, (beat == int'(len)) ? 1 : 0);
      last_rdata = rdata;
      tick;
      a = adv(a, size, burst);
    end
    rready = 1'b0;
    chk("rvalid_drop", rvalid, 0);
    chk("arready_back", arready, 1);
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic [31:0] waddr;
    logic [31:0] raddr;
    logic [31:0] init;
    logic [31:0] wdat;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [5];

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{32'h0000_0040, 32'h0000_0040, 32'h1122_3344, 32'hAABB_CCDD, 4'b0101, 32'h11BB_33DD};
    vecs[1] = '{32'h0000_0044, 32'h0000_0044, 32'hFFFF_FFFF, 32'h0000_0000, 4'b1000, 32'h00FF_FFFF};
    vecs[2] = '{32'h0000_0048, 32'h0000_0048, 32'h0000_0000, 32'hCAFE_BABE, 4'b0000, 32'h0000_0000};
    vecs[3] = '{32'h0001_004C, 32'h0000_004C, 32'h0102_0304, 32'hA0B0_C0D0, 4'b0110, 32'h01B0_C004};
    vecs[4] = '{32'hFFFF_FFFC, 32'h0000_FFFC, 32'h89AB_CDEF, 32'h7654_3210, 4'b1111, 32'h7654_3210};

    // Reset values
    #2 areset = 1'b1;
    #1;
    chk("rst_arready", arready, 1);
    chk("rst_awready", awready, 1);
    chk("rst_wready", wready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rid", rid, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_bid", bid, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_wstate", dbg_wstate, 0);
    chk("rst_rstate", dbg_rstate, 0);
    tick; tick;
    areset = 1'b0;
    tick;

    // Preload words 0..79 with random data
    for (int blk = 0; blk < 5; blk++) begin
      for (int i = 0; i < 16; i++) begin wd_buf[i] = $urandom; ws_buf[i] = 4'hF; end
      do_write(32'(blk * 64), 4'd1, 8'd15, 3'd2, 2'b01, -1, 1'b0);
    end

    // Single read of preloaded word
    wd_buf[0] = 32'h1234_5678; ws_buf[0] = 4'hF;
    do_write(32'h400, 4'd2, 8'd0, 3'd2, 2'b01, -1, 1'b0);
    do_read(32'h400, 4'd3, 8'd0, 3'd2, 2'b01, -1, 0, 1'b0);
    chk("single_read", last_rdata, 32'h1234_5678);

    // Byte-strobe table
    foreach (vecs[v]) begin
      wd_buf[0] = vecs[v].init; ws_buf[0] = 4'hF;
      do_write(vecs[v].waddr, 4'd5, 8'd0, 3'd2, 2'b01, -1, 1'b0);
      wd_buf[0] = vecs[v].wdat; ws_buf[0] = vecs[v].strb;
      do_write(vecs[v].waddr, 4'd5, 8'd0, 3'd2, 2'b01, -1, 1'b0);
      do_read(vecs[v].raddr, 4'd6, 8'd0, 3'd2, 2'b01, -1, 0, 1'b0);
      chk($sformatf("vec%0d", v), last_rdata, vecs[v].exp);
    end

    // Burst read with a 2-cycle stall on beat 1
    do_read(32'h0, 4'd7, 8'd3, 3'd2, 2'b01, 1, 2, 1'b0);
    // FIXED burst read repeats the same word
    do_read(32'h8, 4'd8, 8'd2, 3'd2, 2'b00, -1, 0, 1'b0);

    // wlast early on a 2-beat burst -> SLVERR, then clean write -> OKAY
    for (int i = 0; i < 2; i++) begin wd_buf[i] = $urandom; ws_buf[i] = 4'hF; end
    do_write(32'h60, 4'd9, 8'd1, 3'd2, 2'b01, 0, 1'b0);
    do_write(32'h60, 4'd9, 8'd1, 3'd2, 2'b01, -1, 1'b0);
    do_read(32'h60, 4'd9, 8'd1, 3'd2, 2'b01, -1, 0, 1'b0);

    // Simultaneous AR and AW
    arid = 4'd1; araddr = 32'h100; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    awid = 4'd2; awaddr = 32'h104; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    chk("sim_arready", arready, 1);
    chk("sim_awready", awready, 1);
    tick;
    arvalid = 1'b0; awvalid = 1'b0;
    chk("sim_rvalid", rvalid, 1);
    chk("sim_wready", wready, 1);
    chk("sim_rdata", rdata, m[widx(32'h100)]);
    wvalid = 1'b1; wdata = 32'h5A5A_0F0F; wstrb = 4'hF; wlast = 1'b1; rready = 1'b1;
    tick;
    model_write(32'h104, 32'h5A5A_0F0F, 4'hF);
    wvalid = 1'b0; wlast = 1'b0; rready = 1'b0;
    chk("sim_bvalid", bvalid, 1);
    chk("sim_bid", bid, 2);
    chk("sim_rdone", rvalid, 0);
    bready = 1'b1;
    tick;
    bready = 1'b0;
    do_read(32'h104, 4'd4, 8'd0, 3'd2, 2'b01, -1, 0, 1'b0);

    // Reset mid-read and mid-write
    for (int i = 0; i < 4; i++) begin wd_buf[i] = $urandom; ws_buf[i] = 4'hF; end
    do_write(32'h800, 4'd1, 8'd3, 3'd2, 2'b01, -1, 1'b0);
    awid = 4'd3; awaddr = 32'h900; awlen = 8'd3; awburst = 2'b01; awvalid = 1'b1;
    tick;
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wlast = 1'b0;
    tick;
    model_write(32'h900, 32'hDEAD_BEEF, 4'hF);
    wvalid = 1'b0;
    arid = 4'd2; araddr = 32'h800; arlen = 8'd3; arburst = 2'b01; arvalid = 1'b1;
    tick;
    arvalid = 1'b0; rready = 1'b1;
    chk("rr_beat0", rdata, m[widx(32'h800)]);
    tick;
    chk("rr_beat1", rdata, m[widx(32'h804)]);
    tick;
    chk("rr_beat2_valid", rvalid, 1);
    areset = 1'b1;
    #1;
    chk("rr_rvalid", rvalid, 0);
    chk("rr_wready", wready, 0);
    chk("rr_arready", arready, 1);
    chk("rr_awready", awready, 1);
    chk("rr_bvalid", bvalid, 0);
    chk("rr_rdata", rdata, 0);
    rready = 1'b0;
    tick;
    areset = 1'b0;
    tick;
    chk("rr_bvalid_after", bvalid, 0);
    do_read(32'h900, 4'd6, 8'd0, 3'd2, 2'b01, -1, 0, 1'b0);
    chk("rr_partial_commit", last_rdata, 32'hDEAD_BEEF);

    // Randomized traffic against the model
    for (int it = 0; it < 40; it++) begin
      logic [7:0]  len;
      logic [2:0]  sz;
      logic [1:0]  bu;
      logic [31:0] ad;
      int bad;
      sz = 3'($urandom_range(0, 3));
      bu = 2'($urandom_range(0, 2));
      ad = 32'($urandom_range(0, 32'h150));
      if ($urandom_range(0, 1) == 1) begin
        len = 8'($urandom_range(0, 3));
        bad = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 32'(len))) : -1;
        for (int i = 0; i < 4; i++) begin wd_buf[i] = $urandom; ws_buf[i] = 4'($urandom); end
        do_write(ad, 4'($urandom), len, sz, bu, bad, 1'b1);
      end else begin
        len = 8'($urandom_range(0, 7));
        do_read(ad, 4'($urandom), len, sz, bu, -1, 0, 1'b1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
